huffman_ctrl: RTL and testbench

HUFFMAN_CTRL -- requirements
Module: huffman_ctrl

---
 rtl/huffman_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_huffman_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_ctrl.sv
// huffman_ctrl: frame-level controller around a Huffman encoder core.
// Feeds frame_len source bytes to the encoder, flushes the encoder until it
// has been quiet for FLUSH_CYCLES, buffers encoder words in a small FWFT FIFO
// and signals done once the buffer has drained.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, frame_len          frame request and length in bytes
//   src_valid/src_data/src_ready       source byte handshake
//   enc_enable/enc_in_enable/enc_data  encoder control and input byte
//   enc_out_valid/enc_data_out         encoder output word
//   dst_valid/dst_data/dst_ready       output word handshake (fall-through)
//   busy, done, overflow, word_count   status
module huffman_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] frame_len,
    input  logic        src_valid,
    input  logic [7:0]  src_data,
    output logic        src_ready,
    output logic        enc_enable,
    output logic        enc_in_enable,
    output logic [7:0]  enc_data,
    input  logic        enc_out_valid,
    input  logic [15:0] enc_data_out,
    output logic        dst_valid,
    output logic [15:0] dst_data,
    input  logic        dst_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] word_count
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned IDLE_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        len_q;
    logic [15:0]        byte_cnt_q;
    logic [IDLE_W-1:0]  idle_cnt_q;
    logic [15:0]        word_cnt_q;
    logic               ovf_q;
    logic               done_q;
    logic               enc_in_en_q;
    logic [7:0]         enc_data_q;

    logic [15:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   fill_q;

    logic               src_ready_c;
    logic               start_ok, xfer, last_byte;
    logic               fifo_full, fifo_empty, rd_en, wr_req, wr_en, drop;
    logic [IDLE_W-1:0]  idle_nxt;
    logic               flush_done, drain_done;
    logic [CNT_W-1:0]   free_cnt;

    // Handshake and buffer qualifiers shared by the FSM and datapath
    always_comb begin
        fifo_full  = (fill_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (fill_q == '0);
        free_cnt   = CNT_W'(FIFO_DEPTH) - fill_q;
        start_ok   = (state_q == S_IDLE) && start;
        xfer       = src_valid && src_ready_c;
        last_byte  = xfer && ((byte_cnt_q + 16'd1) == len_q);
        rd_en      = !fifo_empty && dst_ready;
        wr_req     = enc_out_valid && (state_q != S_IDLE);
        // A full buffer still accepts a word when a read frees a slot this cycle
        wr_en      = wr_req && (!fifo_full || rd_en);
        drop       = wr_req && fifo_full && !rd_en;
        idle_nxt   = enc_out_valid ? '0 : idle_cnt_q + IDLE_W'(1);
        flush_done = (state_q == S_FLUSH) && (idle_nxt == IDLE_W'(FLUSH_CYCLES));
        // A word landing in the same cycle keeps the drain going
        drain_done = (state_q == S_DRAIN) && fifo_empty && !wr_req;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start && (frame_len != 16'd0)) state_d = S_FEED;
            S_FEED:  if (last_byte)  state_d = S_FLUSH;
            S_FLUSH: if (flush_done) state_d = S_DRAIN;
            S_DRAIN: if (drain_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        src_ready_c = 1'b0;
        enc_enable  = 1'b0;
        busy        = (state_q != S_IDLE);
        unique case (state_q)
            S_FEED: begin
                enc_enable  = 1'b1;
                src_ready_c = (free_cnt >= CNT_W'(2)) && (byte_cnt_q < len_q);
            end
            S_FLUSH: enc_enable = 1'b1;
            default: ;
        endcase
    end

    // Frame counters, encoder input stage and status
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            word_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            enc_in_en_q <= 1'b0;
            enc_data_q  <= '0;
        end else begin
            done_q      <= (start_ok && (frame_len == 16'd0)) || drain_done;
            enc_in_en_q <= xfer;
            if (xfer) enc_data_q <= src_data;
            if (start_ok) begin
                byte_cnt_q <= '0;
                word_cnt_q <= '0;
                ovf_q      <= 1'b0;
                if (frame_len != 16'd0) len_q <= frame_len;
            end else begin
                if (xfer) byte_cnt_q <= byte_cnt_q + 16'd1;
                if (wr_en && (word_cnt_q != 16'hFFFF)) word_cnt_q <= word_cnt_q + 16'd1;
                if (drop) ovf_q <= 1'b1;
            end
            // Held at zero while feeding so FLUSH always starts from a clean count
            if (state_q == S_FEED)       idle_cnt_q <= '0;
            else if (state_q == S_FLUSH) idle_cnt_q <= idle_nxt;
        end
    end

    // Output buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({wr_en, rd_en})
                2'b10:   fill_q <= fill_q + CNT_W'(1);
                2'b01:   fill_q <= fill_q - CNT_W'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Buffer storage
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= enc_data_out;
    end

    assign src_ready     = src_ready_c;
    assign enc_in_enable = enc_in_en_q;
    assign enc_data      = enc_data_q;
    assign dst_valid     = !fifo_empty;
    assign dst_data      = mem[rd_ptr_q];
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign word_count    = word_cnt_q;

endmodule

// File: tb/tb_huffman_ctrl.sv
// Testbench for huffman_ctrl: directed frames plus randomized traffic,
// checked each cycle against a queue-based reference model.
module tb_huffman_ctrl;

    localparam int DEPTH = 4;
    localparam int FLUSH = 16;

    logic        clk = 1'b0;
    logic        rst, start, src_valid, enc_out_valid, dst_ready;
    logic [15:0] frame_len, enc_data_out;
    logic [7:0]  src_data;
    logic        src_ready, enc_enable, enc_in_enable, dst_valid, busy, done, overflow;
    logic [7:0]  enc_data;
    logic [15:0] dst_data, word_count;

    huffman_ctrl #(.FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .enc_enable(enc_enable), .enc_in_enable(enc_in_enable), .enc_data(enc_data),
        .enc_out_valid(enc_out_valid), .enc_data_out(enc_data_out),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
        .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame phase, counters and the buffer as a queue
    typedef enum {M_IDLE, M_FEED, M_FLUSH, M_DRAIN} mph_t;
    mph_t m_ph;
    int   m_len, m_bytes, m_idle, m_words, m_edata;
    bit   m_ovf, m_done, m_ein;
    int   fifo[$];
    bit   model_ok = 1'b0;

    function automatic bit m_src_ready();
        return (m_ph == M_FEED) && ((DEPTH - fifo.size()) >= 2) && (m_bytes < m_len);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph = M_IDLE; m_len = 0; m_bytes = 0; m_idle = 0; m_words = 0;
            m_edata = 0; m_ovf = 0; m_done = 0; m_ein = 0;
            fifo.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            bit xfer, rd, wr;
            int pre;
            pre  = fifo.size();
            xfer = src_valid && m_src_ready();
            rd   = (pre > 0) && dst_ready;
            wr   = enc_out_valid && (m_ph != M_IDLE);
            m_done = 0;
            m_ein  = xfer;
            if (xfer) m_edata = src_data;
            if (rd) void'(fifo.pop_front());
            if (wr) begin
                if (pre < DEPTH || rd) begin
                    fifo.push_back(enc_data_out);
                    if (m_words < 65535) m_words++;
                end else begin
                    m_ovf = 1;
                end
            end
            case (m_ph)
                M_IDLE: if (start) begin
                    m_bytes = 0; m_words = 0; m_ovf = 0;
                    if (frame_len != 0) begin m_len = frame_len; m_ph = M_FEED; end
                    else m_done = 1;
                end
                M_FEED: if (xfer) begin
                    m_bytes++;
                    if (m_bytes == m_len) begin m_ph = M_FLUSH; m_idle = 0; end
                end
                M_FLUSH: begin
                    if (enc_out_valid) m_idle = 0; else m_idle++;
                    if (m_idle == FLUSH) m_ph = M_DRAIN;
                end
                M_DRAIN: if (pre == 0 && !wr) begin m_done = 1; m_ph = M_IDLE; end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok) begin
            chk("busy", busy, m_ph != M_IDLE);
            chk("enc_enable", enc_enable, (m_ph == M_FEED) || (m_ph == M_FLUSH));
            chk("src_ready", src_ready, m_src_ready());
            chk("enc_in_enable", enc_in_enable, m_ein);
            chk("enc_data", enc_data, m_edata);
            chk("done", done, m_done);
            chk("overflow", overflow, m_ovf);
            chk("word_count", word_count, m_words);
            chk("dst_valid", dst_valid, fifo.size() > 0);
            if (fifo.size() > 0) chk("dst_data", dst_data, fifo[0]);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int budget);
        int pulses;
        pulses = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (done) pulses++;
            if (!busy) break;
        end
        chk({name, "_done_pulses"}, pulses, 1);
        chk({name, "_idle_after"}, busy, 0);
    endtask

    logic [7:0] a_bytes [3];
    int dst_pct, enc_pct;

    initial begin
        rst = 1; start = 0; frame_len = 0; src_valid = 0; src_data = 0;
        enc_out_valid = 0; enc_data_out = 0; dst_ready = 1;
        cyc(); cyc();
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_enc_data", enc_data, 0);
        chk("rst_dst_valid", dst_valid, 0);

        // Three-byte frame, one encoder word
        a_bytes[0] = 8'd5; a_bytes[1] = 8'd68; a_bytes[2] = 8'd50;
        start = 1; frame_len = 16'd3; cyc(); start = 0;
        chk("A_src_ready", src_ready, 1);
        for (int i = 0; i < 3; i++) begin
            src_valid = 1; src_data = a_bytes[i]; cyc();
            chk("A_ein", enc_in_enable, 1);
            chk("A_edata", enc_data, a_bytes[i]);
        end
        src_valid = 0;
        chk("A_flush_src_ready", src_ready, 0);
        chk("A_flush_enc_enable", enc_enable, 1);
        enc_out_valid = 1; enc_data_out = 16'hA001; cyc(); enc_out_valid = 0;
        wait_done("A", 60);
        chk("A_word_count", word_count, 1);
        cyc();
        chk("A_done_low", done, 0);

        // Zero-length frame
        start = 1; frame_len = 16'd0; cyc(); start = 0;
        chk("B_done", done, 1);
        chk("B_busy", busy, 0);
        chk("B_enc_enable", enc_enable, 0);
        cyc();
        chk("B_done_low", done, 0);
        chk("B_busy_low", busy, 0);

        // Buffer fills, two words dropped, then drains in order
        dst_ready = 0;
        start = 1; frame_len = 16'd8; cyc(); start = 0;
        for (int i = 0; i < 6; i++) begin
            enc_out_valid = 1; enc_data_out = 16'h0100 + 16'(i); cyc();
            if (i == 1) chk("C_src_ready_two_free", src_ready, 1);
            if (i == 2) chk("C_src_ready_drop", src_ready, 0);
        end
        enc_out_valid = 0;
        chk("C_word_count", word_count, 4);
        chk("C_overflow", overflow, 1);
        chk("C_dst_valid", dst_valid, 1);
        dst_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("C_order", dst_data, 32'h100 + 32'(k));
            cyc();
        end
        chk("C_empty", dst_valid, 0);
        src_valid = 1; src_data = 8'h3C;
        wait_done("C", 100);
        src_valid = 0;
        chk("C_overflow_sticky", overflow, 1);

        // Full buffer with simultaneous read and write
        dst_ready = 0;
        start = 1; frame_len = 16'd4; cyc(); start = 0;
        chk("D_overflow_cleared", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            enc_out_valid = 1; enc_data_out = 16'h0200 + 16'(i); cyc();
        end
        dst_ready = 1; enc_out_valid = 1; enc_data_out = 16'h02FF; cyc();
        enc_out_valid = 0; dst_ready = 0;
        chk("D_overflow", overflow, 0);
        chk("D_word_count", word_count, 5);
        chk("D_head", dst_data, 32'h201);
        dst_ready = 1; src_valid = 1; src_data = 8'h11;
        wait_done("D", 100);
        src_valid = 0;

        // Reset in the middle of a frame
        start = 1; frame_len = 16'd8; cyc(); start = 0;
        src_valid = 1; src_data = 8'h77; cyc(); cyc();
        src_valid = 0; rst = 1; cyc(); rst = 0;
        chk("E_busy", busy, 0);
        chk("E_src_ready", src_ready, 0);
        chk("E_enc_enable", enc_enable, 0);
        chk("E_ein", enc_in_enable, 0);
        chk("E_enc_data", enc_data, 0);
        chk("E_dst_valid", dst_valid, 0);
        chk("E_done", done, 0);
        chk("E_overflow", overflow, 0);
        chk("E_word_count", word_count, 0);
        start = 1; frame_len = 16'd2; src_valid = 1; src_data = 8'h42; cyc(); start = 0;
        wait_done("E", 60);
        src_valid = 0;

        // Start re-pulsed mid-frame is ignored
        start = 1; frame_len = 16'd5; cyc(); start = 0;
        src_valid = 1; src_data = 8'h09; cyc();
        start = 1; frame_len = 16'd1; cyc(); start = 0;
        cyc(); cyc();
        chk("F_src_ready_4", src_ready, 1);
        chk("F_busy", busy, 1);
        cyc();
        chk("F_src_ready_5", src_ready, 0);
        src_valid = 0;
        wait_done("F", 60);

        // Randomized traffic alternating congestion and drain phases
        for (int c = 0; c < 4000; c++) begin
            if ((c / 256) % 2 == 0) begin dst_pct = 15; enc_pct = 50; end
            else begin dst_pct = 85; enc_pct = 8; end
            rst           = ($urandom_range(0, 499) == 0);
            start         = ($urandom_range(0, 15) == 0);
            frame_len     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            src_valid     = ($urandom_range(0, 3) != 0);
            src_data      = 8'($urandom);
            dst_ready     = ($urandom_range(0, 99) < dst_pct);
            enc_out_valid = enc_enable ? ($urandom_range(0, 99) < enc_pct)
                                       : ($urandom_range(0, 31) == 0);
            enc_data_out  = 16'($urandom);
            cyc();
        end
        rst = 0; start = 0; src_valid = 0; enc_out_valid = 0; dst_ready = 1;
        repeat (5) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
